// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated power-of-two transmit FIFO.
// Bit timing comes from a system-clock baud divisor; frame format is
// DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   wr_en, wr_data   push request and byte to queue
//   full, empty      FIFO occupancy flags (registered)
//   level            FIFO occupancy count (registered)
//   overflow         one-cycle pulse when a push is dropped
//   busy             high while a frame is in progress
//   tx_done          one-cycle pulse after the last stop bit of a frame
//   txd              serial line, idle high, driven from a flop
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_AW:0]     level,
  output logic                 overflow,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 txd
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned BW    = $clog2(BAUD_DIV);
  localparam int unsigned CW    = 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]        level_nxt;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [DATA_BITS-1:0] rd_data;
  logic                 push, pop, baud_end, last_stop;

  // Even parity is the XOR of the data bits; odd is its inverse.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  assign rd_data   = mem[rd_ptr];
  assign push      = wr_en && !full;
  assign baud_end  = (baud_cnt == BW'(BAUD_DIV - 1));
  assign last_stop = (bit_cnt == CW'(STOP_BITS - 1));
  // Pop on leaving IDLE, or on leaving the final stop bit with data waiting.
  assign pop = !empty && ((state == IDLE) ||
                          (state == STOP && baud_end && last_stop));

  // Occupancy after this edge's push/pop.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, flags and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      level    <= level_nxt;
      full     <= (level_nxt == LW'(DEPTH));
      empty    <= (level_nxt == '0);
      // Uses the pre-edge full, so a same-edge pop does not rescue the push.
      overflow <= wr_en && full;
    end
  end

  // Frame FSM; txd is set on each transition so it is purely a flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift    <= rd_data;
            par_bit  <= parity_of(rd_data);
            txd      <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == CW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                txd   <= par_bit;
                state <= PAR;
              end else begin
                txd   <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        PAR: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (last_stop) begin
              bit_cnt <= '0;
              tx_done <= 1'b1;
              if (pop) begin
                // Back-to-back: next start bit follows with no idle gap.
                shift   <= rd_data;
                par_bit <= parity_of(rd_data);
                txd     <= 1'b0;
                state   <= START;
              end else begin
                txd   <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three instances (8E1 div4 depth4,
// 7O2 div4 depth4, 8N1 div2 depth16). Expected frames are queued as bit
// vectors (bit0 = start bit); per-instance monitors rebuild each frame
// cycle by cycle from txd and compare.
module tb_uart_tx_fifo;

  logic       clk;
  logic [2:0] rst_v, wr_en_v;
  logic [7:0] wd_a, wd_c;
  logic [6:0] wd_b;
  logic [2:0] full_v, empty_v, overflow_v, busy_v, tx_done_v, txd_v;
  logic [2:0] level_a, level_b;
  logic [4:0] level_c;

  int checks = 0;
  int errors = 0;
  int done_cnt [3];
  int ovf_cnt  [3];

  logic [11:0] qa [$];
  logic [11:0] qb [$];
  logic [11:0] qc [$];

  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_AW(2)) u_a (
    .clk(clk), .rst(rst_v[0]), .wr_en(wr_en_v[0]), .wr_data(wd_a),
    .full(full_v[0]), .empty(empty_v[0]), .level(level_a), .overflow(overflow_v[0]),
    .busy(busy_v[0]), .tx_done(tx_done_v[0]), .txd(txd_v[0]));

  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_AW(2)) u_b (
    .clk(clk), .rst(rst_v[1]), .wr_en(wr_en_v[1]), .wr_data(wd_b),
    .full(full_v[1]), .empty(empty_v[1]), .level(level_b), .overflow(overflow_v[1]),
    .busy(busy_v[1]), .tx_done(tx_done_v[1]), .txd(txd_v[1]));

  uart_tx_fifo #(.BAUD_DIV(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(4)) u_c (
    .clk(clk), .rst(rst_v[2]), .wr_en(wr_en_v[2]), .wr_data(wd_c),
    .full(full_v[2]), .empty(empty_v[2]), .level(level_c), .overflow(overflow_v[2]),
    .busy(busy_v[2]), .tx_done(tx_done_v[2]), .txd(txd_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bd_of(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic int nb_of(input int i);
    return (i == 2) ? 10 : 11;
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic q_pop(input int i, output bit ok, output logic [11:0] v);
    ok = (qsize(i) != 0);
    v  = '0;
    if (ok) begin
      case (i)
        0:       v = qa.pop_front();
        1:       v = qb.pop_front();
        default: v = qc.pop_front();
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tx_done_v[i] === 1'b1)  done_cnt[i]++;
      if (overflow_v[i] === 1'b1) ovf_cnt[i]++;
    end
  end

  // Rebuilds one frame from txd, then checks it against the scoreboard.
  task automatic monitor(input int i);
    logic [47:0] samp, ex;
    logic [11:0] exp;
    bit pending, aborted, busy_ok, ok;
    int bd, flen;
    bd = bd_of(i);
    flen = bd * nb_of(i);
    pending = 0;
    forever begin
      if (!pending) begin
        @(negedge clk);
        while (txd_v[i] !== 1'b0 || rst_v[i] !== 1'b0) @(negedge clk);
      end
      pending = 0;
      aborted = 0;
      busy_ok = 1;
      samp = '0;
      for (int c = 0; c < flen; c++) begin
        if (c > 0) @(negedge clk);
        if (rst_v[i] !== 1'b0) begin
          aborted = 1;
          break;
        end
        samp[c] = txd_v[i];
        if (busy_v[i] !== 1'b1) busy_ok = 0;
      end
      if (aborted) continue;
      @(negedge clk);
      chk($sformatf("dut%0d_tx_done_after_frame", i), 32'(tx_done_v[i]), 1);
      pending = (txd_v[i] === 1'b0);
      chk($sformatf("dut%0d_busy_at_done", i), 32'(busy_v[i]), 32'(pending));
      chk($sformatf("dut%0d_busy_during_frame", i), 32'(busy_ok), 1);
      q_pop(i, ok, exp);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL dut%0d_unexpected_frame actual=%0h required=none", i, samp);
      end else begin
        ex = '0;
        for (int c = 0; c < flen; c++) ex[c] = exp[c / bd];
        if (samp !== ex) begin
          errors++;
          $display("FAIL dut%0d_frame actual=%0h required=%0h", i, samp, ex);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  task automatic wait_drain(input int i, input int budget);
    int n;
    n = 0;
    while (qsize(i) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("dut%0d_drain_timeout", i), 32'(qsize(i)), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  logic [11:0] ovf_exp [5] = '{12'h602, 12'h604, 12'h406, 12'h608, 12'h40A};
  logic [11:0] col_exp [5] = '{12'h422, 12'h424, 12'h626, 12'h428, 12'h62A};

  initial begin
    rst_v = 3'b111;
    wr_en_v = '0;
    wd_a = '0;
    wd_b = '0;
    wd_c = '0;
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0;
      ovf_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d_rst_txd", i), 32'(txd_v[i]), 1);
      chk($sformatf("dut%0d_rst_busy", i), 32'(busy_v[i]), 0);
      chk($sformatf("dut%0d_rst_tx_done", i), 32'(tx_done_v[i]), 0);
      chk($sformatf("dut%0d_rst_overflow", i), 32'(overflow_v[i]), 0);
      chk($sformatf("dut%0d_rst_full", i), 32'(full_v[i]), 0);
      chk($sformatf("dut%0d_rst_empty", i), 32'(empty_v[i]), 1);
    end
    chk("dut0_rst_level", 32'(level_a), 0);
    chk("dut2_rst_level", 32'(level_c), 0);
    rst_v = '0;
    @(posedge clk);
    #1;

    // Single 8E1 frame of 0xA5 and write-to-start latency.
    wd_a = 8'hA5;
    wr_en_v[0] = 1'b1;
    qa.push_back(12'h54A);
    @(posedge clk);
    #1;
    wr_en_v[0] = 1'b0;
    chk("lat_k_txd", 32'(txd_v[0]), 1);
    chk("lat_k_level", 32'(level_a), 1);
    @(posedge clk);
    #1;
    chk("lat_k1_txd", 32'(txd_v[0]), 0);
    chk("lat_k1_busy", 32'(busy_v[0]), 1);
    chk("lat_k1_empty", 32'(empty_v[0]), 1);
    wait_drain(0, 200);

    // 7O2 frame of 0x03; 8N1 div-2 back-to-back 0x3C, 0xC3.
    wd_b = 7'h03;
    wr_en_v[1] = 1'b1;
    qb.push_back(12'h706);
    wd_c = 8'h3C;
    wr_en_v[2] = 1'b1;
    qc.push_back(12'h278);
    @(posedge clk);
    #1;
    wr_en_v[1] = 1'b0;
    wd_c = 8'hC3;
    qc.push_back(12'h386);
    @(posedge clk);
    #1;
    wr_en_v[2] = 1'b0;
    wait_drain(1, 200);
    wait_drain(2, 200);

    // Overflow: six consecutive writes into a depth-4 FIFO.
    for (int j = 0; j < 6; j++) begin
      wd_a = 8'(j + 1);
      wr_en_v[0] = 1'b1;
      if (j < 5) qa.push_back(ovf_exp[j]);
      @(posedge clk);
      #1;
      if (j == 4) begin
        chk("ovf_full_after_fill", 32'(full_v[0]), 1);
        chk("ovf_level_after_fill", 32'(level_a), 4);
      end
    end
    wr_en_v[0] = 1'b0;
    chk("ovf_pulse", 32'(overflow_v[0]), 1);
    chk("ovf_level_held", 32'(level_a), 4);
    @(posedge clk);
    #1;
    chk("ovf_pulse_one_cycle", 32'(overflow_v[0]), 0);
    wait_drain(0, 400);

    // Push/pop collision while full on the STOP pop edge (k+45).
    for (int j = 0; j < 6; j++) begin
      wd_a = 8'(8'h11 + j);
      wr_en_v[0] = 1'b1;
      if (j < 5) qa.push_back(col_exp[j]);
      @(posedge clk);
      #1;
    end
    wr_en_v[0] = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("col_full_before", 32'(full_v[0]), 1);
    wd_a = 8'h77;
    wr_en_v[0] = 1'b1;
    @(posedge clk);
    #1;
    wr_en_v[0] = 1'b0;
    chk("col_overflow", 32'(overflow_v[0]), 1);
    chk("col_level", 32'(level_a), 3);
    chk("col_full_after", 32'(full_v[0]), 0);
    chk("col_tx_done", 32'(tx_done_v[0]), 1);
    wait_drain(0, 400);

    // Reset during data bit 3 of 0x21 with two bytes still queued.
    for (int j = 0; j < 3; j++) begin
      wd_a = 8'(8'h21 + j);
      wr_en_v[0] = 1'b1;
      @(posedge clk);
      #1;
    end
    wr_en_v[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("rst_mid_txd_bit3", 32'(txd_v[0]), 0);
    chk("rst_mid_level_before", 32'(level_a), 2);
    rst_v[0] = 1'b1;
    #1;
    chk("rst_mid_txd", 32'(txd_v[0]), 1);
    chk("rst_mid_level", 32'(level_a), 0);
    chk("rst_mid_empty", 32'(empty_v[0]), 1);
    chk("rst_mid_busy", 32'(busy_v[0]), 0);
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("post_rst_txd", 32'(txd_v[0]), 1);
    chk("post_rst_busy", 32'(busy_v[0]), 0);
    chk("post_rst_level", 32'(level_a), 0);

    chk("dut0_done_count", 32'(done_cnt[0]), 11);
    chk("dut1_done_count", 32'(done_cnt[1]), 1);
    chk("dut2_done_count", 32'(done_cnt[2]), 2);
    chk("dut0_ovf_count", 32'(ovf_cnt[0]), 3);
    chk("dut1_ovf_count", 32'(ovf_cnt[1]), 0);
    chk("dut2_ovf_count", 32'(ovf_cnt[2]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
